// File: rtl/arb8_pkg.sv
// Shared sizes and FSM encoding for the 8-way round-robin resource scheduler.
package arb8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;
endpackage

// File: rtl/arb8_sched_rr_pick8.sv
// Combinational rotating-priority pick: first set req bit scanning upward from ptr, mod 8.
module rr_pick8
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             any
);
  logic [IDX_W-1:0] k;

  // Scan from the far end so the closest requester to ptr is written last.
  always_comb begin
    win = ptr;
    k   = ptr;
    for (int i = N_REQ-1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) win = k;
    end
  end

  assign any = |req;
endmodule

// File: rtl/arb8_sched.sv
// 8-requester round-robin scheduler with registered one-hot grant and one-cycle dead time.
// Optional grant hold timeout enabled by defining ARB_TIMEOUT_EN.
module arb8_sched
  import arb8_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             tmo
);
  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, win;
  logic             any, grab, rel, hold_max;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] hold_cnt;

  assign hold_max = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      if (grab)               hold_cnt <= '0;
      else if (state == BUSY) hold_cnt <= hold_cnt + CNT_W'(1);
      // done takes precedence, so a coincident release is not flagged
      tmo <= (state == BUSY) && hold_max && !done;
    end
  end
`else
  assign hold_max = 1'b0;
  assign tmo      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grab      = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: if (any) begin
        state_nxt = BUSY;
        grab      = 1'b1;
      end
      BUSY: if (done || hold_max) begin
        state_nxt = GAP;
        rel       = 1'b1;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // gnt_idx deliberately keeps the last owner after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr     <= '0;
    end else if (grab) begin
      gnt     <= N_REQ'(1) << win;
      gnt_idx <= win;
      gnt_vld <= 1'b1;
      ptr     <= win + IDX_W'(1);
    end else if (rel) begin
      gnt     <= '0;
      gnt_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb8_sched.sv
// Self-checking bench for arb8_sched: vector table, directed corner sequences, random vs model.
module tb_arb8_sched;
  localparam int TMO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb8_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] idx;
  } vec_t;
  vec_t vq[$];

  // behavioural reference: owner index (-1 none), gap flag, pointer, hold length
  int m_owner, m_gap, m_ptr, m_hold, m_tmo, m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [7:0] eg, input logic ev,
                         input logic [2:0] ei, input logic et);
    chk({name, ".gnt"}, 32'(gnt), 32'(eg));
    chk({name, ".vld"}, 32'(gnt_vld), 32'(ev));
    chk({name, ".tmo"}, 32'(tmo), 32'(et));
    if (ev) chk({name, ".idx"}, 32'(gnt_idx), 32'(ei));
  endtask

  function automatic void add(input logic rs, input logic [7:0] r, input logic d,
                              input logic [7:0] g, input logic v, input logic [2:0] i);
    vec_t e;
    e.rst = rs; e.req = r; e.done = d; e.gnt = g; e.vld = v; e.idx = i;
    vq.push_back(e);
  endfunction

  function automatic void mdl_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_tmo = 0; m_idx = 0;
  endfunction

  function automatic void mdl_step(input logic [7:0] r, input logic d);
    m_tmo = 0;
    if (m_gap != 0) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (m_ptr + i) % 8;
        if (r[k]) begin
          m_owner = k; m_idx = k; m_ptr = (k + 1) % 8; m_hold = 0;
          break;
        end
      end
    end else if (d) begin
      m_owner = -1; m_gap = 1;
    end else if (TMO_EN && m_hold == TMO - 1) begin
      m_owner = -1; m_gap = 1; m_tmo = 1;
    end else begin
      m_hold++;
    end
  endfunction

  initial begin
    logic [7:0] g;
    logic [7:0] r;
    logic       d;

    // --- vector table ---
    // single requester, done ignored in IDLE, release and regrant after GAP
    add(1, 8'h00, 1, 8'h00, 0, 0);
    add(0, 8'h04, 0, 8'h04, 1, 2);
    add(0, 8'h04, 1, 8'h00, 0, 0);
    add(0, 8'h04, 1, 8'h00, 0, 0);
    add(0, 8'h04, 0, 8'h04, 1, 2);
    add(0, 8'h00, 1, 8'h00, 0, 0);
    // fairness with all requesting: 0..7 then back to 0
    for (int k = 0; k < 9; k++) begin
      g = 8'h01 << (k % 8);
      add(k == 0, 8'hFF, 0, g, 1, 3'(k % 8));
      add(0, 8'hFF, 1, 8'h00, 0, 0);
      add(0, 8'hFF, 0, 8'h00, 0, 0);
    end
    // pointer wrap: grant 6 leaves ptr=7, then 7 beats 0, then 0
    add(1, 8'h40, 0, 8'h40, 1, 6);
    add(0, 8'h40, 1, 8'h00, 0, 0);
    add(0, 8'h81, 0, 8'h00, 0, 0);
    add(0, 8'h81, 0, 8'h80, 1, 7);
    add(0, 8'h81, 1, 8'h00, 0, 0);
    add(0, 8'h81, 0, 8'h00, 0, 0);
    add(0, 8'h81, 0, 8'h01, 1, 0);

    do_reset();
    chk_out("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    chk("reset.idx", 32'(gnt_idx), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      req  = vq[i].req;
      done = vq[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vq[i].gnt, vq[i].vld, vq[i].idx, 1'b0);
    end
    done = 1'b0;

    // --- hold stability: owner 3 kept while req moves away and drops ---
    do_reset();
    req = 8'h08;
    step();
    chk_out("hold.grant", 8'h08, 1'b1, 3'd3, 1'b0);
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("hold.mid%0d", i), 8'h08, 1'b1, 3'd3, 1'b0);
    end
    req = 8'h00;
    step();
    chk_out("hold.drop", 8'h08, 1'b1, 3'd3, 1'b0);
    req = 8'h10; done = 1'b1;
    step();
    done = 1'b0;
    chk_out("hold.rel", 8'h00, 1'b0, 3'd0, 1'b0);
    step();
    step();
    chk_out("hold.next", 8'h10, 1'b1, 3'd4, 1'b0);

    // --- timeout / indefinite hold ---
    do_reset();
    req = 8'h01;
    step();
    for (int i = 1; i < TMO; i++) begin
      step();
      chk_out($sformatf("tmo.busy%0d", i), 8'h01, 1'b1, 3'd0, 1'b0);
    end
    step();
    if (TMO_EN) begin
      chk_out("tmo.fire", 8'h00, 1'b0, 3'd0, 1'b1);
      step();
      chk_out("tmo.pulse_end", 8'h00, 1'b0, 3'd0, 1'b0);
      // done in the last allowed cycle beats the timeout
      req = 8'h00;
      step();
      req = 8'h02;
      step();
      chk_out("tmo.regrant", 8'h02, 1'b1, 3'd1, 1'b0);
      for (int i = 1; i < TMO; i++) step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk_out("tmo.done_wins", 8'h00, 1'b0, 3'd0, 1'b0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        chk_out($sformatf("notmo.hold%0d", i), 8'h01, 1'b1, 3'd0, 1'b0);
        step();
      end
    end
    req = 8'h00; done = 1'b0;

    // --- asynchronous reset mid-grant ---
    do_reset();
    req = 8'h20;
    step();
    chk_out("arst.grant", 8'h20, 1'b1, 3'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst.drop", 8'h00, 1'b0, 3'd0, 1'b0);
    chk("arst.idx", 32'(gnt_idx), 32'd0);
    step();
    rst_n = 1'b1;
    req = 8'h21;
    step();
    chk_out("arst.after", 8'h01, 1'b1, 3'd0, 1'b0);
    req = 8'h00;

    // --- randomized traffic vs reference model ---
    do_reset();
    mdl_reset();
    for (int c = 0; c < 500; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      d = ($urandom_range(0, 3) == 0);
      req = r; done = d;
      mdl_step(r, d);
      step();
      g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      chk_out($sformatf("rnd%0d", c), g, m_owner >= 0, 3'(m_idx), m_tmo != 0);
    end
    req = '0; done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
